// File: rtl/fakeram_dp_init.sv
// fakeram_dp_init: dual-port behavioural SRAM with lane write masks,
// selectable read latency and read-during-write policy, and a post-reset init sweep.
module fakeram_dp_init #(
  parameter int BITS = 16,
  parameter int WORD_DEPTH = 8192,
  parameter int ADDR_WIDTH = 13,
  parameter int MASK_GRAN = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE = 0,
  parameter logic [BITS-1:0] INIT_VALUE = '0,
  localparam int LANES = BITS / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  rw0_ce_in,
  input  logic                  rw0_we_in,
  input  logic [LANES-1:0]      rw0_wmask_in,
  input  logic [ADDR_WIDTH-1:0] rw0_addr_in,
  input  logic [BITS-1:0]       rw0_wd_in,
  output logic [BITS-1:0]       rw0_rd_out,
  output logic                  rw0_rd_valid_out,
  input  logic                  rw1_ce_in,
  input  logic                  rw1_we_in,
  input  logic [LANES-1:0]      rw1_wmask_in,
  input  logic [ADDR_WIDTH-1:0] rw1_addr_in,
  input  logic [BITS-1:0]       rw1_wd_in,
  output logic [BITS-1:0]       rw1_rd_out,
  output logic                  rw1_rd_valid_out,
  output logic                  collision_out,
  output logic                  err_oob_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [BITS-1:0]       mem [WORD_DEPTH];

  logic [1:0]            ce, we;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [LANES-1:0]      wmask [2];
  logic [BITS-1:0]       wd [2];

  logic                  ready, same;
  logic [1:0]            acc, inr, wr;
  logic [BITS-1:0]       old [2];
  logic [BITS-1:0]       merged [2];
  logic [BITS-1:0]       rdata [2];
  logic [BITS-1:0]       rd [2];
  logic [1:0]            vld;

  assign ce = {rw1_ce_in, rw0_ce_in};
  assign we = {rw1_we_in, rw0_we_in};
  assign addr[0] = rw0_addr_in;
  assign addr[1] = rw1_addr_in;
  assign wmask[0] = rw0_wmask_in;
  assign wmask[1] = rw1_wmask_in;
  assign wd[0] = rw0_wd_in;
  assign wd[1] = rw1_wd_in;
  assign ready = (state == READY);

  function automatic logic [BITS-1:0] lane_merge(
    input logic [BITS-1:0]  base,
    input logic             en,
    input logic [LANES-1:0] m,
    input logic [BITS-1:0]  d
  );
    logic [BITS-1:0] r;
    r = base;
    for (int i = 0; i < LANES; i++)
      if (en && m[i])
        r[i*MASK_GRAN +: MASK_GRAN] = d[i*MASK_GRAN +: MASK_GRAN];
    return r;
  endfunction

  // Port 1 lanes go on first so port 0 wins any lane both ports write.
  always_comb begin
    acc = '0;
    inr = '0;
    wr = '0;
    same = (addr[0] == addr[1]);
    for (int p = 0; p < 2; p++) begin
      acc[p] = ready && ce[p];
      inr[p] = {1'b0, addr[p]} < DEPTH;
      wr[p] = acc[p] && we[p] && inr[p];
      old[p] = mem[addr[p]];
    end
    merged[0] = lane_merge(
      lane_merge(old[0], wr[1] && same, wmask[1], wd[1]),
      wr[0], wmask[0], wd[0]);
    merged[1] = lane_merge(
      lane_merge(old[1], wr[1], wmask[1], wd[1]),
      wr[0] && same, wmask[0], wd[0]);
    for (int p = 0; p < 2; p++)
      rdata[p] = inr[p] ? ((RDW_MODE != 0) ? merged[p] : old[p])
                        : INIT_VALUE;
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[init_addr] <= INIT_VALUE;
    end else begin
      if (wr[1]) mem[addr[1]] <= merged[1];
      if (wr[0]) mem[addr[0]] <= merged[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      init_addr <= '0;
      init_done <= 1'b0;
      collision_out <= 1'b0;
      err_oob_out <= 1'b0;
    end else begin
      collision_out <= wr[0] && wr[1] && same && |(wmask[0] & wmask[1]);
      if (|(acc & ~inr)) err_oob_out <= 1'b1;
      unique case (state)
        INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == LAST) begin
            state <= READY;
            init_done <= 1'b1;
          end
        end
        READY: begin
        end
      endcase
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic            v1;
    logic [BITS-1:0] d1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1 <= 1'b0;
        d1 <= '0;
      end else begin
        v1 <= acc[p];
        if (acc[p]) d1 <= rdata[p];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic            v2;
      logic [BITS-1:0] d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign rd[p] = d2;
      assign vld[p] = v2;
    end else begin : g_lat1
      assign rd[p] = d1;
      assign vld[p] = v1;
    end
  end

  assign rw0_rd_out = rd[0];
  assign rw1_rd_out = rd[1];
  assign rw0_rd_valid_out = vld[0];
  assign rw1_rd_valid_out = vld[1];

endmodule

// File: tb/tb_fakeram_dp_init.sv
// tb_fakeram_dp_init: two configurations driven by shared stimulus,
// each checked against an array-snapshot model of the memory.
module tb_fakeram_dp_init;

  localparam logic [15:0] IV = 16'hA5A5;
  localparam int DEP [2] = '{12, 16};
  localparam int LAT [2] = '{2, 1};
  localparam int RDW [2] = '{1, 0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic want_rst = 1'b1;

  logic rw0_ce_in, rw0_we_in, rw1_ce_in, rw1_we_in;
  logic [1:0] rw0_wmask_in, rw1_wmask_in;
  logic [3:0] rw0_addr_in, rw1_addr_in;
  logic [15:0] rw0_wd_in, rw1_wd_in;

  logic [1:0][1:0][15:0] rd_o;
  logic [1:0][1:0] vld_o;
  logic [1:0] done_o, col_o, err_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mm [2][16];
  int edges;
  bit pv [2][2];
  logic [15:0] pd [2][2];
  bit ev [2][2];
  logic [15:0] ed [2][2];
  bit ecol [2], eerr [2], edone [2];

  always #5 clk = ~clk;

  fakeram_dp_init #(
    .BITS(16), .WORD_DEPTH(12), .ADDR_WIDTH(4), .MASK_GRAN(8),
    .READ_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(16'hA5A5)
  ) dut_a (
    .clk(clk), .rst(rst), .init_done(done_o[0]),
    .rw0_ce_in(rw0_ce_in), .rw0_we_in(rw0_we_in),
    .rw0_wmask_in(rw0_wmask_in), .rw0_addr_in(rw0_addr_in),
    .rw0_wd_in(rw0_wd_in), .rw0_rd_out(rd_o[0][0]),
    .rw0_rd_valid_out(vld_o[0][0]),
    .rw1_ce_in(rw1_ce_in), .rw1_we_in(rw1_we_in),
    .rw1_wmask_in(rw1_wmask_in), .rw1_addr_in(rw1_addr_in),
    .rw1_wd_in(rw1_wd_in), .rw1_rd_out(rd_o[0][1]),
    .rw1_rd_valid_out(vld_o[0][1]),
    .collision_out(col_o[0]), .err_oob_out(err_o[0])
  );

  fakeram_dp_init #(
    .BITS(16), .WORD_DEPTH(16), .ADDR_WIDTH(4), .MASK_GRAN(8),
    .READ_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(16'hA5A5)
  ) dut_b (
    .clk(clk), .rst(rst), .init_done(done_o[1]),
    .rw0_ce_in(rw0_ce_in), .rw0_we_in(rw0_we_in),
    .rw0_wmask_in(rw0_wmask_in), .rw0_addr_in(rw0_addr_in),
    .rw0_wd_in(rw0_wd_in), .rw0_rd_out(rd_o[1][0]),
    .rw0_rd_valid_out(vld_o[1][0]),
    .rw1_ce_in(rw1_ce_in), .rw1_we_in(rw1_we_in),
    .rw1_wmask_in(rw1_wmask_in), .rw1_addr_in(rw1_addr_in),
    .rw1_wd_in(rw1_wd_in), .rw1_rd_out(rd_o[1][1]),
    .rw1_rd_valid_out(vld_o[1][1]),
    .collision_out(col_o[1]), .err_oob_out(err_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    edges = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mm[k][i] = IV;
      for (int p = 0; p < 2; p++) begin
        pv[k][p] = 0; pd[k][p] = '0;
        ev[k][p] = 0; ed[k][p] = '0;
      end
      ecol[k] = 0; eerr[k] = 0; edone[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [15:0] nm [16];
    logic [15:0] cur [2];
    bit acc [2], inr [2], wr [2];
    bit rdy;
    logic [3:0] a [2];
    logic [1:0] m [2];
    logic [15:0] d [2];
    logic c [2], w [2];
    a[0] = rw0_addr_in; a[1] = rw1_addr_in;
    m[0] = rw0_wmask_in; m[1] = rw1_wmask_in;
    d[0] = rw0_wd_in; d[1] = rw1_wd_in;
    c[0] = rw0_ce_in; c[1] = rw1_ce_in;
    w[0] = rw0_we_in; w[1] = rw1_we_in;
    for (int k = 0; k < 2; k++) begin
      rdy = (edges >= DEP[k]);
      for (int i = 0; i < 16; i++) nm[i] = mm[k][i];
      for (int p = 0; p < 2; p++) begin
        acc[p] = rdy && c[p];
        inr[p] = (int'(a[p]) < DEP[k]);
        wr[p] = acc[p] && w[p] && inr[p];
      end
      // apply port 1 then port 0, so port 0 owns shared lanes
      for (int p = 1; p >= 0; p--)
        if (wr[p])
          for (int l = 0; l < 2; l++)
            if (m[p][l]) nm[a[p]][l*8 +: 8] = d[p][l*8 +: 8];
      for (int p = 0; p < 2; p++)
        cur[p] = !inr[p] ? IV : (RDW[k] != 0 ? nm[a[p]] : mm[k][a[p]]);
      ecol[k] = wr[0] && wr[1] && (a[0] == a[1]) && ((m[0] & m[1]) != 0);
      for (int p = 0; p < 2; p++) begin
        if (acc[p] && !inr[p]) eerr[k] = 1;
        if (LAT[k] == 1) begin
          ev[k][p] = acc[p];
          if (acc[p]) ed[k][p] = cur[p];
        end else begin
          ev[k][p] = pv[k][p];
          if (pv[k][p]) ed[k][p] = pd[k][p];
          pv[k][p] = acc[p];
          if (acc[p]) pd[k][p] = cur[p];
        end
      end
      for (int i = 0; i < 16; i++) mm[k][i] = nm[i];
    end
    edges++;
    for (int k = 0; k < 2; k++) edone[k] = (edges >= DEP[k]);
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d_init_done", k), done_o[k], edone[k]);
      chk($sformatf("k%0d_collision", k), col_o[k], ecol[k]);
      chk($sformatf("k%0d_err_oob", k), err_o[k], eerr[k]);
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("k%0d_p%0d_rd_valid", k, p), vld_o[k][p], ev[k][p]);
        chk($sformatf("k%0d_p%0d_rd", k, p), rd_o[k][p], ed[k][p]);
      end
    end
  endtask

  task automatic step(
    input logic c0, input logic w0, input logic [1:0] m0,
    input logic [3:0] a0, input logic [15:0] d0,
    input logic c1, input logic w1, input logic [1:0] m1,
    input logic [3:0] a1, input logic [15:0] d1
  );
    @(negedge clk);
    rst = want_rst;
    rw0_ce_in = c0; rw0_we_in = w0; rw0_wmask_in = m0;
    rw0_addr_in = a0; rw0_wd_in = d0;
    rw1_ce_in = c1; rw1_we_in = w1; rw1_wmask_in = m1;
    rw1_addr_in = a1; rw1_wd_in = d1;
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 4'd0, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
  endtask

  task automatic rand_step();
    logic [3:0] a0, a1;
    a0 = 4'($urandom_range(0, 15));
    a1 = ($urandom_range(0, 1) == 0) ? a0 : 4'($urandom_range(0, 15));
    step($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), a0,
         16'($urandom),
         $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), a1,
         16'($urandom));
  endtask

  initial begin
    rw0_ce_in = 0; rw0_we_in = 0; rw0_wmask_in = 0;
    rw0_addr_in = 0; rw0_wd_in = 0;
    rw1_ce_in = 0; rw1_we_in = 0; rw1_wmask_in = 0;
    rw1_addr_in = 0; rw1_wd_in = 0;
    model_reset();
    #1 rst = 1'b1;
    #1 cmp_all();
    idle();
    idle();
    want_rst = 1'b0;

    // sweep with traffic offered every cycle
    for (int i = 0; i < 16; i++)
      step(1, 1'($urandom), 2'b11, 4'($urandom_range(0, 11)),
           16'($urandom), 1, 0, 2'b00, 4'd7, 16'h0);
    step(1, 0, 2'b00, 4'd7, 16'h0, 1, 0, 2'b00, 4'd7, 16'h0);
    chk("init_rd7_b", rd_o[1][0], 16'hA5A5);
    idle();
    chk("init_rd7_a", rd_o[0][0], 16'hA5A5);

    // lane masks
    step(1, 1, 2'b11, 4'd3, 16'h1234, 0, 0, 2'b00, 4'd0, 16'h0);
    step(1, 1, 2'b10, 4'd3, 16'hFF99, 0, 0, 2'b00, 4'd0, 16'h0);
    step(1, 0, 2'b00, 4'd3, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    chk("mask_b", rd_o[1][0], 16'hFF34);
    idle();
    chk("mask_a", rd_o[0][0], 16'hFF34);
    chk("mask_a_vld", vld_o[0][0], 1);

    // read during write
    step(1, 1, 2'b11, 4'd5, 16'h0001, 0, 0, 2'b00, 4'd0, 16'h0);
    step(1, 1, 2'b11, 4'd5, 16'h0002, 1, 0, 2'b00, 4'd5, 16'h0);
    chk("rdw_old_b0", rd_o[1][0], 16'h0001);
    chk("rdw_old_b1", rd_o[1][1], 16'h0001);
    idle();
    chk("rdw_new_a0", rd_o[0][0], 16'h0002);
    chk("rdw_new_a1", rd_o[0][1], 16'h0002);

    // same-address collisions
    step(1, 1, 2'b11, 4'd9, 16'hAAAA, 1, 1, 2'b01, 4'd9, 16'hBBBB);
    chk("coll_a", col_o[0], 1);
    chk("coll_b", col_o[1], 1);
    step(1, 0, 2'b00, 4'd9, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    chk("coll_clr_a", col_o[0], 0);
    chk("coll_rd_b", rd_o[1][0], 16'hAAAA);
    idle();
    chk("coll_rd_a", rd_o[0][0], 16'hAAAA);
    step(1, 1, 2'b10, 4'd9, 16'hAAAA, 1, 1, 2'b01, 4'd9, 16'hBBBB);
    chk("nocoll_a", col_o[0], 0);
    step(1, 0, 2'b00, 4'd9, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    chk("split_rd_b", rd_o[1][0], 16'hAABB);
    idle();
    chk("split_rd_a", rd_o[0][0], 16'hAABB);

    // out of range on port 1 only for the 12-word instance
    step(1, 1, 2'b11, 4'd2, 16'h1357, 1, 1, 2'b11, 4'd13, 16'hDEAD);
    chk("oob_err_a", err_o[0], 1);
    chk("oob_err_b", err_o[1], 0);
    step(1, 0, 2'b00, 4'd2, 16'h0, 1, 0, 2'b00, 4'd13, 16'h0);
    idle();
    chk("oob_rd_a", rd_o[0][1], 16'hA5A5);
    chk("oob_p0_a", rd_o[0][0], 16'h1357);

    for (int i = 0; i < 600; i++) rand_step();

    // reset with latency-2 reads in flight
    step(1, 0, 2'b00, 4'd3, 16'h0, 1, 0, 2'b00, 4'd4, 16'h0);
    step(1, 0, 2'b00, 4'd5, 16'h0, 1, 0, 2'b00, 4'd6, 16'h0);
    #2 rst = 1'b1;
    want_rst = 1'b1;
    #1 model_reset();
    cmp_all();
    idle();
    idle();
    want_rst = 1'b0;
    for (int i = 0; i < 16; i++) rand_step();
    step(1, 0, 2'b00, 4'd3, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0);
    chk("rst_rd3_b", rd_o[1][0], 16'hA5A5);
    idle();
    chk("rst_rd3_a", rd_o[0][0], 16'hA5A5);
    for (int i = 0; i < 100; i++) rand_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
